// File: rtl/ve_lane_pwl_act.sv
// ve_lane_pwl_act: multi-lane fixed-point piecewise-linear activation, 3-stage pipeline with
// a runtime-programmable coefficient table. Optional saturation counter: VE_PWL_SAT_CNT_EN.
module ve_lane_pwl_act #(
    parameter int LANES     = 4,
    parameter int DW        = 16,
    parameter int FRAC      = 8,
    parameter int COEF_W    = 16,
    parameter int SEG_BITS  = 4,
    parameter int SEG_SHIFT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    input  logic [LANES-1:0]      in_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_data,
    input  logic                  cfg_we,
    input  logic [SEG_BITS-1:0]   cfg_addr,
    input  logic [COEF_W-1:0]     cfg_slope,
    input  logic [COEF_W-1:0]     cfg_icpt,
    output logic [31:0]           sat_cnt
);
    localparam int SEGS = 1 << SEG_BITS;
    localparam int PW = DW + COEF_W;
    localparam int SW = PW + 2;
    localparam logic signed [SW-1:0] RND = SW'(1 << (FRAC - 1));
    localparam logic signed [SW-1:0] YMAX = SW'((1 << (DW - 1)) - 1);
    localparam logic signed [SW-1:0] YMIN = SW'(-(1 << (DW - 1)));

    logic v1_q, v2_q, v3_q, adv1, adv2, adv3;
    logic signed [COEF_W-1:0] slope_q [SEGS];
    logic signed [COEF_W-1:0] icpt_q [SEGS];
    logic signed [DW:0] xsh [LANES];
    logic signed [DW:0] sidx [LANES];
    logic [SEG_BITS-1:0] seg [LANES];
    logic [LANES*DW-1:0] x1_q, x2_q, out_q, y3;
    logic [LANES-1:0] m1_q, m2_q;
    logic signed [COEF_W-1:0] sl1_q [LANES];
    logic signed [COEF_W-1:0] ic1_q [LANES];
    logic signed [COEF_W-1:0] ic2_q [LANES];
    logic signed [PW-1:0] p2_q [LANES];
    logic signed [SW-1:0] r3 [LANES];

    assign adv3      = !v3_q || out_ready;
    assign adv2      = !v2_q || adv3;
    assign adv1      = !v1_q || adv2;
    assign in_ready  = adv1;
    assign out_valid = v3_q;
    assign out_data  = out_q;

    // Segment index per lane: shifted x re-centred and clamped to the table range
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            xsh[i]  = $signed({in_data[i*DW+DW-1], in_data[i*DW +: DW]}) >>> SEG_SHIFT;
            sidx[i] = xsh[i] + (DW+1)'(SEGS / 2);
            seg[i]  = sidx[i] < 0 ? '0 : sidx[i] > SEGS - 1 ? SEG_BITS'(SEGS - 1) : sidx[i][SEG_BITS-1:0];
        end
    end

    // Coefficient table; reset restores the identity function
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SEGS; s++) begin
                slope_q[s] <= COEF_W'(1 << FRAC);
                icpt_q[s]  <= '0;
            end
        end else if (cfg_we) begin
            slope_q[cfg_addr] <= cfg_slope;
            icpt_q[cfg_addr]  <= cfg_icpt;
        end
    end

    // Stage valids advance only into empty or draining stages
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            if (adv1) v1_q <= in_valid;
            if (adv2) v2_q <= v1_q;
            if (adv3) v3_q <= v2_q;
        end
    end

    // S1: capture x, mask and the coefficients of the selected segment
    always_ff @(posedge clk) begin
        if (in_valid && adv1) begin
            x1_q <= in_data;
            m1_q <= in_mask;
            for (int i = 0; i < LANES; i++) begin
                sl1_q[i] <= slope_q[seg[i]];
                ic1_q[i] <= icpt_q[seg[i]];
            end
        end
    end

    // S2: full-precision product slope*x
    always_ff @(posedge clk) begin
        if (v1_q && adv2) begin
            x2_q <= x1_q;
            m2_q <= m1_q;
            for (int i = 0; i < LANES; i++) begin
                p2_q[i]  <= PW'(sl1_q[i]) * PW'($signed(x1_q[i*DW +: DW]));
                ic2_q[i] <= ic1_q[i];
            end
        end
    end

    // S3 combinational: add aligned intercept, round half up, saturate, apply bypass
    always_comb begin
        y3 = '0;
        for (int i = 0; i < LANES; i++) begin
            r3[i] = (SW'(p2_q[i]) + (SW'(ic2_q[i]) <<< FRAC) + RND) >>> FRAC;
            y3[i*DW +: DW] = !m2_q[i] ? x2_q[i*DW +: DW] :
                             r3[i] > YMAX ? YMAX[DW-1:0] :
                             r3[i] < YMIN ? YMIN[DW-1:0] : r3[i][DW-1:0];
        end
    end

    // S3 output register, held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else if (v2_q && adv3) out_q <= y3;
    end

`ifdef VE_PWL_SAT_CNT_EN
    logic [LANES-1:0] sat3, sat3_q;
    logic [31:0] nsat, cnt_q, cnt_d;
    logic [32:0] sum;

    // Saturation flags of unmasked lanes
    always_comb begin
        for (int i = 0; i < LANES; i++) sat3[i] = m2_q[i] && (r3[i] > YMAX || r3[i] < YMIN);
    end

    // Flags travel with out_data so they are counted when the beat leaves
    always_ff @(posedge clk) begin
        if (rst) sat3_q <= '0;
        else if (v2_q && adv3) sat3_q <= sat3;
    end

    // Sticky count of saturated lanes in delivered beats
    always_comb begin
        nsat = '0;
        for (int i = 0; i < LANES; i++) nsat = nsat + 32'(sat3_q[i]);
        sum   = {1'b0, cnt_q} + {1'b0, nsat};
        cnt_d = (v3_q && out_ready) ? (sum[32] ? '1 : sum[31:0]) : cnt_q;
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign sat_cnt = cnt_q;
`else
    assign sat_cnt = '0;
`endif
endmodule

// File: tb/tb_ve_lane_pwl_act.sv
// tb_ve_lane_pwl_act: directed and randomized checks of ve_lane_pwl_act against an arithmetic model.
module tb_ve_lane_pwl_act;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, cfg_we;
    logic [63:0] in_data, out_data;
    logic [3:0] in_mask, cfg_addr;
    logic [15:0] cfg_slope, cfg_icpt;
    logic [31:0] sat_cnt;

    always #5 clk = ~clk;

    ve_lane_pwl_act dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_slope(cfg_slope), .cfg_icpt(cfg_icpt),
        .sat_cnt(sat_cnt)
    );

    int errors = 0, checks = 0, cyc = 0;
    int sl_m [16];
    int ic_m [16];
    logic [63:0] exp_q [$];
    int satq [$];
    int accq [$];
    logic [63:0] got [$];
    int lat [$];
    longint cnt_m = 0;
    logic prev_stall = 1'b0, rst_prev = 1'b0;
    logic [63:0] prev_out = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void table_reset();
        for (int s = 0; s < 16; s++) begin
            sl_m[s] = 256;
            ic_m[s] = 0;
        end
    endfunction

    // y = sat(slope*x + icpt) in Q8.8 with round half up; bypass lanes pass x
    function automatic void model(input logic [63:0] d, input logic [3:0] m, output logic [63:0] y, output int ns);
        ns = 0;
        y = '0;
        for (int i = 0; i < 4; i++) begin
            int x, s;
            longint r;
            x = int'($signed(d[i*16 +: 16]));
            s = (x >>> 8) + 8;
            if (s < 0) s = 0;
            if (s > 15) s = 15;
            r = (longint'(sl_m[s]) * x + longint'(ic_m[s]) * 256 + 128) >>> 8;
            if (!m[i]) y[i*16 +: 16] = d[i*16 +: 16];
            else if (r > 32767) begin y[i*16 +: 16] = 16'h7FFF; ns++; end
            else if (r < -32768) begin y[i*16 +: 16] = 16'h8000; ns++; end
            else y[i*16 +: 16] = 16'(r);
        end
    endfunction

    // Compare process: every negedge, outputs are checked against the model
    always @(negedge clk) begin
        logic [63:0] y;
        int ns;
        cyc++;
        if (rst_prev) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_data", out_data, 64'd0);
        end
        if (prev_stall && !rst_prev) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", out_data, prev_out);
        end
`ifdef VE_PWL_SAT_CNT_EN
        chk("sat_cnt", 64'(sat_cnt), 64'(cnt_m));
`else
        chk("sat_cnt", 64'(sat_cnt), 64'd0);
`endif
        if (rst) begin
            exp_q.delete();
            satq.delete();
            accq.delete();
            table_reset();
            cnt_m = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
                else begin
                    chk("out_data", out_data, exp_q.pop_front());
                    cnt_m = cnt_m + satq.pop_front();
                    if (cnt_m > 64'hFFFF_FFFF) cnt_m = 64'hFFFF_FFFF;
                    lat.push_back(cyc - accq.pop_front());
                    got.push_back(out_data);
                end
            end
            if (in_valid && in_ready) begin
                model(in_data, in_mask, y, ns);
                exp_q.push_back(y);
                satq.push_back(ns);
                accq.push_back(cyc);
            end
            if (cfg_we) begin
                sl_m[cfg_addr] = int'($signed(cfg_slope));
                ic_m[cfg_addr] = int'($signed(cfg_icpt));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_out = out_data;
        rst_prev = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic [3:0] m);
        int t;
        in_valid = 1'b1;
        in_data = d;
        in_mask = m;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (t == 200) chk("send_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [15:0] s, input logic [15:0] c);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_slope = s;
        cfg_icpt = c;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_pops(input int n);
        for (int t = 0; t < 300 && got.size() < n; t++) @(negedge clk);
        if (got.size() < n) chk("pop_timeout", 64'(got.size()), 64'(n));
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int b, k;
        table_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_slope = '0; cfg_icpt = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        // identity after reset, latency 3
        send(64'h7FFF_0000_FF00_0100, 4'hF);
        wait_pops(1);
        chk("t1_identity", got[0], 64'h7FFF_0000_FF00_0100);
        chk("t1_latency", 64'(lat[0]), 64'd3);
        // programmed segment 9
        cfg_write(4'd9, 16'h0080, 16'h0040);
        send({4{16'h0100}}, 4'hF);
        wait_pops(2);
        chk("t2_seg9", got[1], {4{16'h00C0}});
        // saturation both directions
        cfg_write(4'd15, 16'h0400, 16'h0000);
        cfg_write(4'd0, 16'h0400, 16'h0000);
        send(64'h0000_0000_8000_7000, 4'hF);
        wait_pops(3);
        chk("t3_sat", got[2], 64'h0000_0000_8000_7FFF);
        tick();
`ifdef VE_PWL_SAT_CNT_EN
        chk("t3_sat_cnt", 64'(sat_cnt), 64'd2);
`else
        chk("t3_sat_cnt", 64'(sat_cnt), 64'd0);
`endif
        // bypass mask
        send({4{16'h0100}}, 4'b0101);
        wait_pops(4);
        chk("t4_mask", got[3], 64'h0100_00C0_0100_00C0);
        // backpressure: 8 beats, out_ready low for 5 cycles
        b = got.size();
        k = 0;
        for (int t = 0; t < 60 && (k < 8 || got.size() < b + 8); t++) begin
            in_valid = k < 8;
            in_data = {16'(k*16+3), 16'(k*16+2), 16'(k*16+1), 16'(k*16)};
            in_mask = 4'hF;
            out_ready = !(t >= 2 && t < 7);
            @(negedge clk);
            if (t == 6) begin
                chk("t5_in_ready_low", 64'(in_ready), 64'd0);
                chk("t5_held_beats", 64'(exp_q.size()), 64'd3);
            end
            if (in_valid && in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_pops(b + 8);
        for (int j = 0; j < 8; j++)
            chk("t5_order", got[b+j], {16'(j*16+3), 16'(j*16+2), 16'(j*16+1), 16'(j*16)});
        // write in the same cycle as a seg-9 beat is accepted
        b = got.size();
        in_valid = 1'b1; in_data = {4{16'h0100}}; in_mask = 4'hF;
        cfg_we = 1'b1; cfg_addr = 4'd9; cfg_slope = 16'h0200; cfg_icpt = 16'h0000;
        @(negedge clk);
        chk("t6_race_ready", 64'(in_ready), 64'd1);
        tick();
        cfg_we = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_pops(b + 2);
        chk("t6_old_coef", got[b], {4{16'h00C0}});
        chk("t6_new_coef", got[b+1], {4{16'h0200}});
        // reset with three beats in flight
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b = got.size();
        send({4{16'h0100}}, 4'hF);
        wait_pops(b + 1);
        chk("t6_post_rst_identity", got[b], {4{16'h0100}});
        chk("t6_no_stale", 64'(got.size()), 64'(b + 1));
        // randomized traffic with table writes and occasional reset
        for (int t = 0; t < 3000; t++) begin
            in_valid = $urandom_range(3) != 0;
            in_data = {$urandom, $urandom};
            in_mask = 4'($urandom);
            out_ready = $urandom_range(3) != 0;
            cfg_we = $urandom_range(7) == 0;
            cfg_addr = 4'($urandom);
            cfg_slope = $urandom_range(1) ? 16'($urandom) : 16'($urandom_range(1023));
            cfg_icpt = 16'($urandom);
            rst = $urandom_range(499) == 0;
            tick();
        end
        in_valid = 1'b0; cfg_we = 1'b0; rst = 1'b0; out_ready = 1'b1;
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
